// File: rtl/bsg_gateway_pll_drp_ctrl.sv
// rtl/bsg_gateway_pll_drp_ctrl.sv - PLL_ADV DRP reconfiguration sequencer with lock qualification
//
// Purpose: accepts masked DRP register writes, holds the PLL in reset while
// doing a read-modify-write per entry, then releases reset and qualifies
// re-lock before pulsing done_o.
// Ports:
//   clk_i, reset_i                  clock (also PLL DCLK), sync active-high reset
//   cfg_v_i/cfg_ready_o             entry handshake; cfg_addr_i/data_i/mask_i/last_i payload
//   pll_rst_o                       PLL RST
//   drp_den_o/dwe_o/daddr_o/di_o    DRP request; drp_do_i/drp_drdy_i response
//   pll_locked_i                    raw LOCKED (already synchronized)
//   locked_o, busy_o, done_o, err_o qualified lock, activity, completion pulse, sticky error
module bsg_gateway_pll_drp_ctrl #(
    parameter int rst_hold_p     = 16,
    parameter int lock_hold_p    = 64,
    parameter int lock_timeout_p = 65535,
    parameter int drdy_timeout_p = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        cfg_v_i,
    input  logic [4:0]  cfg_addr_i,
    input  logic [15:0] cfg_data_i,
    input  logic [15:0] cfg_mask_i,
    input  logic        cfg_last_i,
    output logic        cfg_ready_o,
    output logic        pll_rst_o,
    output logic        drp_den_o,
    output logic        drp_dwe_o,
    output logic [4:0]  drp_daddr_o,
    output logic [15:0] drp_di_o,
    input  logic [15:0] drp_do_i,
    input  logic        drp_drdy_i,
    input  logic        pll_locked_i,
    output logic        locked_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);
    localparam int RstW  = $clog2(rst_hold_p + 1);
    localparam int HoldW = $clog2(lock_hold_p + 1);
    localparam int TmoW  = $clog2(lock_timeout_p + 1);
    localparam int WaitW = $clog2(drdy_timeout_p + 1);

    localparam logic [RstW-1:0]  RstLast  = RstW'(rst_hold_p - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(lock_hold_p - 1);
    localparam logic [TmoW-1:0]  TmoLast  = TmoW'(lock_timeout_p - 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(drdy_timeout_p - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_NEXT, S_RST_HOLD, S_LOCK_WAIT
    } state_e;

    state_e             state_q, state_d;
    logic [4:0]         addr_q, addr_d;
    logic [15:0]        data_q, data_d, mask_q, mask_d, di_q, di_d;
    logic               last_q, last_d;
    logic               pll_rst_q, pll_rst_d, den_q, den_d, dwe_q, dwe_d;
    logic               ready_q, ready_d, busy_q, busy_d, done_q, done_d;
    logic               err_q, err_d, locked_q, locked_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic [RstW-1:0]    rsth_q, rsth_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic [TmoW-1:0]    tmo_q, tmo_d;
    logic               accept;

    assign accept = cfg_v_i & ready_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        mask_d    = mask_q;
        last_d    = last_q;
        di_d      = di_q;
        pll_rst_d = pll_rst_q;
        err_d     = err_q;
        locked_d  = locked_q;
        done_d    = 1'b0;
        wait_d    = wait_q;
        rsth_d    = rsth_q;
        hold_d    = hold_q;
        tmo_d     = tmo_q;

        if (accept) begin
            addr_d = cfg_addr_i;
            data_d = cfg_data_i;
            mask_d = cfg_mask_i;
            last_d = cfg_last_i;
            err_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    locked_d  = 1'b0;
                    pll_rst_d = 1'b1;
                    state_d   = S_RD_REQ;
                end else if (locked_q && !pll_locked_i) begin
                    locked_d = 1'b0;
                    err_d    = 1'b1;
                end
            end
            S_RD_REQ: begin
                wait_d  = '0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (drp_drdy_i) begin
                    di_d    = (drp_do_i & mask_q) | (data_q & ~mask_q);
                    state_d = S_WR_REQ;
                end else if (wait_q == WaitLast) begin
                    // Abandon the entry but still walk through reset release.
                    err_d   = 1'b1;
                    rsth_d  = '0;
                    state_d = S_RST_HOLD;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            S_WR_REQ: begin
                wait_d  = '0;
                state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (drp_drdy_i) begin
                    // The DRDY cycle itself counts as the first hold cycle.
                    rsth_d  = RstW'(1);
                    state_d = last_q ? S_RST_HOLD : S_NEXT;
                end else if (wait_q == WaitLast) begin
                    err_d   = 1'b1;
                    rsth_d  = '0;
                    state_d = S_RST_HOLD;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            S_NEXT: begin
                if (accept) state_d = S_RD_REQ;
            end
            S_RST_HOLD: begin
                if (rsth_q >= RstLast) begin
                    pll_rst_d = 1'b0;
                    hold_d    = '0;
                    tmo_d     = '0;
                    state_d   = S_LOCK_WAIT;
                end else begin
                    rsth_d = rsth_q + RstW'(1);
                end
            end
            S_LOCK_WAIT: begin
                if (!pll_locked_i) begin
                    hold_d = '0;
                end else if (hold_q == HoldLast) begin
                    locked_d = 1'b1;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
                if (state_d == S_LOCK_WAIT) begin
                    if (tmo_q == TmoLast) begin
                        err_d    = 1'b1;
                        done_d   = 1'b1;
                        locked_d = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        tmo_d = tmo_q + TmoW'(1);
                    end
                end
            end
            default: state_d = S_LOCK_WAIT;
        endcase

        // Strobes and status are registered from the next state.
        den_d   = (state_d == S_RD_REQ) || (state_d == S_WR_REQ);
        dwe_d   = (state_d == S_WR_REQ);
        ready_d = (state_d == S_IDLE) || (state_d == S_NEXT);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_LOCK_WAIT;
            addr_q    <= '0;
            data_q    <= '0;
            mask_q    <= '0;
            last_q    <= 1'b0;
            di_q      <= '0;
            pll_rst_q <= 1'b0;
            den_q     <= 1'b0;
            dwe_q     <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            locked_q  <= 1'b0;
            wait_q    <= '0;
            rsth_q    <= '0;
            hold_q    <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            mask_q    <= mask_d;
            last_q    <= last_d;
            di_q      <= di_d;
            pll_rst_q <= pll_rst_d;
            den_q     <= den_d;
            dwe_q     <= dwe_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            locked_q  <= locked_d;
            wait_q    <= wait_d;
            rsth_q    <= rsth_d;
            hold_q    <= hold_d;
            tmo_q     <= tmo_d;
        end
    end

    assign cfg_ready_o = ready_q;
    assign pll_rst_o   = pll_rst_q;
    assign drp_den_o   = den_q;
    assign drp_dwe_o   = dwe_q;
    assign drp_daddr_o = addr_q;
    assign drp_di_o    = di_q;
    assign locked_o    = locked_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_bsg_gateway_pll_drp_ctrl.sv
// tb/tb_bsg_gateway_pll_drp_ctrl.sv - self-checking bench for bsg_gateway_pll_drp_ctrl
module tb_bsg_gateway_pll_drp_ctrl;
    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        cfg_v_i = 1'b0;
    logic [4:0]  cfg_addr_i = '0;
    logic [15:0] cfg_data_i = '0;
    logic [15:0] cfg_mask_i = '0;
    logic        cfg_last_i = 1'b0;
    logic [15:0] drp_do_i = '0;
    logic        drp_drdy_i = 1'b0;
    logic        pll_locked_i = 1'b0;
    logic        cfg_ready_o, pll_rst_o, drp_den_o, drp_dwe_o;
    logic [4:0]  drp_daddr_o;
    logic [15:0] drp_di_o;
    logic        locked_o, busy_o, done_o, err_o;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bsg_gateway_pll_drp_ctrl dut (
        .clk_i(clk), .reset_i(reset_i),
        .cfg_v_i(cfg_v_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
        .cfg_mask_i(cfg_mask_i), .cfg_last_i(cfg_last_i), .cfg_ready_o(cfg_ready_o),
        .pll_rst_o(pll_rst_o), .drp_den_o(drp_den_o), .drp_dwe_o(drp_dwe_o),
        .drp_daddr_o(drp_daddr_o), .drp_di_o(drp_di_o), .drp_do_i(drp_do_i),
        .drp_drdy_i(drp_drdy_i), .pll_locked_i(pll_locked_i), .locked_o(locked_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    // DRP register file model; lat=0 means DRDY never returns.
    logic [15:0] drp_mem [32];
    logic [21:0] acc_log [$];
    int          lat = 1;
    bit          lat_rand = 1'b0;
    int          pend = 0;
    logic        pend_we = 1'b0;
    logic [4:0]  pend_a = '0;
    logic [15:0] pend_d = '0;
    bit          resp_we = 1'b0;

    always @(posedge clk) begin
        #1;
        drp_drdy_i = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                drp_drdy_i = 1'b1;
                resp_we = pend_we;
                if (pend_we) drp_mem[pend_a] = pend_d;
                else drp_do_i = drp_mem[pend_a];
            end
        end
        if (drp_den_o) begin
            acc_log.push_back({drp_dwe_o, drp_daddr_o, drp_di_o});
            pend_we = drp_dwe_o;
            pend_a = drp_daddr_o;
            pend_d = drp_di_o;
            pend = lat_rand ? int'($urandom_range(1, 4)) : lat;
        end
    end

    int   rst_falls = 0;
    int   rdy_viol = 0;
    logic prev_rst = 1'b0;
    always @(negedge clk) begin
        if (prev_rst && !pll_rst_o) rst_falls++;
        prev_rst = pll_rst_o;
        if (cfg_ready_o && (drp_den_o || drp_drdy_i || pend > 0)) rdy_viol++;
    end

    task automatic present_entry(input logic [4:0] a, input logic [15:0] d, input logic [15:0] m,
                                 input logic last, input int gap, output bit ok);
        int g = 0;
        ok = 1'b0;
        cfg_addr_i = a; cfg_data_i = d; cfg_mask_i = m; cfg_last_i = last;
        if (gap == 0) cfg_v_i = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            if (cfg_ready_o) begin
                if (g == gap) begin
                    cfg_v_i = 1'b1;
                    ok = 1'b1;
                    @(negedge clk);
                    break;
                end
                g++;
            end
            @(negedge clk);
        end
        cfg_v_i = 1'b0;
    endtask

    task automatic wait_wr_drdy(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (drp_drdy_i && resp_we) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_rst_low(output int k);
        k = -1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (!pll_rst_o) begin k = i; break; end
        end
    endtask

    task automatic wait_done(output int k);
        k = -1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (done_o) begin k = i; break; end
        end
    endtask

    task automatic test_reset;
        logic [30:0] obs;
        @(negedge clk);
        reset_i = 1'b1; cfg_v_i = 1'b0; pll_locked_i = 1'b0;
        repeat (3) @(negedge clk);
        obs = {pll_rst_o, drp_den_o, drp_dwe_o, drp_daddr_o, drp_di_o,
               locked_o, err_o, done_o, cfg_ready_o, busy_o};
        n_chk++;
        if (obs !== {3'b000, 5'd0, 16'd0, 5'b00001}) begin
            n_fail++; $display("FAIL reset_state: got %h expected %h", obs, {3'b000, 5'd0, 16'd0, 5'b00001});
        end
    endtask

    task automatic test_powerup;
        int k;
        reset_i = 1'b0;
        pll_locked_i = 1'b0;
        repeat (10) @(negedge clk);
        pll_locked_i = 1'b1;
        wait_done(k);
        n_chk++;
        if (k != 64 || locked_o !== 1'b1) begin
            n_fail++; $display("FAIL powerup_lock: got cycles=%0d locked=%b expected 64 1", k, locked_o);
        end
        @(negedge clk);
        n_chk++;
        if ({done_o, busy_o, cfg_ready_o, err_o} !== 4'b0010) begin
            n_fail++; $display("FAIL powerup_idle: got %b expected 0010", {done_o, busy_o, cfg_ready_o, err_o});
        end
    endtask

    task automatic test_single;
        bit ok; int k;
        lat_rand = 1'b0; lat = 3;
        drp_mem[8] = 16'hA5A5;
        acc_log.delete();
        pll_locked_i = 1'b0;
        present_entry(5'd8, 16'h1234, 16'hFF00, 1'b1, 0, ok);
        n_chk++;
        if (!ok || {pll_rst_o, drp_den_o, drp_dwe_o, drp_daddr_o} !== {3'b110, 5'd8}) begin
            n_fail++; $display("FAIL single_accept: got ok=%b %b expected 1 %b", ok,
                               {pll_rst_o, drp_den_o, drp_dwe_o, drp_daddr_o}, {3'b110, 5'd8});
        end
        wait_wr_drdy(ok);
        wait_rst_low(k);
        n_chk++;
        if (!ok || k != 16) begin
            n_fail++; $display("FAIL single_rst_hold: got drdy=%b cycles=%0d expected 1 16", ok, k);
        end
        n_chk++;
        if (acc_log.size() != 2 || acc_log[0][21:16] !== {1'b0, 5'd8} || acc_log[1] !== {1'b1, 5'd8, 16'hA534}) begin
            n_fail++; $display("FAIL single_access: got n=%0d w=%h expected 2 %h", acc_log.size(),
                               (acc_log.size() > 1) ? acc_log[1] : 22'h0, {1'b1, 5'd8, 16'hA534});
        end
        pll_locked_i = 1'b1;
        wait_done(k);
        n_chk++;
        if (k != 64 || locked_o !== 1'b1 || err_o !== 1'b0) begin
            n_fail++; $display("FAIL single_relock: got %0d %b %b expected 64 1 0", k, locked_o, err_o);
        end
    endtask

    task automatic test_burst;
        logic [15:0] shadow [32];
        logic [21:0] exp_q [$];
        logic [4:0]  a;
        logic [15:0] d, m;
        int          gaps [3] = '{0, 0, 5};
        int          f0, v0, k;
        bit          ok, all_ok;
        for (int i = 0; i < 32; i++) begin
            drp_mem[i] = 16'($urandom);
            shadow[i] = drp_mem[i];
        end
        lat_rand = 1'b1;
        acc_log.delete();
        pll_locked_i = 1'b0;
        f0 = rst_falls; v0 = rdy_viol;
        all_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 5'($urandom_range(0, 31));
            d = 16'($urandom);
            m = 16'($urandom);
            exp_q.push_back({1'b0, a, 16'h0});
            shadow[a] = (shadow[a] & m) | (d & ~m);
            exp_q.push_back({1'b1, a, shadow[a]});
            present_entry(a, d, m, i == 2, gaps[i], ok);
            all_ok &= ok;
        end
        wait_wr_drdy(ok);
        n_chk++;
        if (!all_ok || !ok || rst_falls != f0 || pll_rst_o !== 1'b1) begin
            n_fail++; $display("FAIL burst_rst_held: got acc=%b drdy=%b falls=%0d rst=%b expected 1 1 %0d 1",
                               all_ok, ok, rst_falls, pll_rst_o, f0);
        end
        n_chk++;
        if (acc_log.size() != 6) begin
            n_fail++; $display("FAIL burst_count: got %0d expected 6", acc_log.size());
        end
        for (int i = 0; i < 6 && i < acc_log.size(); i++) begin
            n_chk++;
            if ((i % 2 == 0 && acc_log[i][21:16] !== exp_q[i][21:16]) || (i % 2 == 1 && acc_log[i] !== exp_q[i])) begin
                n_fail++; $display("FAIL burst_access%0d: got %h expected %h", i, acc_log[i], exp_q[i]);
            end
        end
        n_chk++;
        if (rdy_viol != v0) begin
            n_fail++; $display("FAIL burst_ready_low: got %0d violations expected 0", rdy_viol - v0);
        end
        wait_rst_low(k);
        pll_locked_i = 1'b1;
        wait_done(k);
        n_chk++;
        if (k != 64 || locked_o !== 1'b1) begin
            n_fail++; $display("FAIL burst_relock: got %0d %b expected 64 1", k, locked_o);
        end
    endtask

    task automatic test_drdy_timeout;
        bit ok; int k, k2;
        logic [4:0]  a = 5'($urandom_range(0, 31));
        logic [15:0] d = 16'($urandom);
        lat_rand = 1'b0; lat = 0;
        acc_log.delete();
        pll_locked_i = 1'b0;
        present_entry(a, d, 16'h0F0F, 1'b0, 0, ok);
        k = -1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (err_o) begin k = i; break; end
        end
        n_chk++;
        if (!ok || k != 256) begin
            n_fail++; $display("FAIL drdy_tmo_err: got ok=%b cycles=%0d expected 1 256", ok, k);
        end
        wait_rst_low(k2);
        n_chk++;
        if (k2 != 16 || acc_log.size() != 1) begin
            n_fail++; $display("FAIL drdy_tmo_release: got %0d n=%0d expected 16 1", k2, acc_log.size());
        end
        pll_locked_i = 1'b1;
        wait_done(k);
        n_chk++;
        if (k != 64 || locked_o !== 1'b1 || err_o !== 1'b1) begin
            n_fail++; $display("FAIL drdy_tmo_done: got %0d %b %b expected 64 1 1", k, locked_o, err_o);
        end
        lat = 1;
    endtask

    task automatic test_reset_in_next;
        bit ok; bit seen = 1'b0;
        lat_rand = 1'b0; lat = 2;
        pll_locked_i = 1'b0;
        present_entry(5'($urandom_range(0, 31)), 16'($urandom), 16'($urandom), 1'b0, 0, ok);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cfg_ready_o) begin seen = 1'b1; break; end
        end
        n_chk++;
        if (!ok || !seen || pll_rst_o !== 1'b1 || err_o !== 1'b0) begin
            n_fail++; $display("FAIL next_state: got %b%b%b%b expected 1110", ok, seen, pll_rst_o, err_o);
        end
        reset_i = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({pll_rst_o, drp_den_o, cfg_ready_o, busy_o} !== 4'b0001) begin
            n_fail++; $display("FAIL reset_in_next: got %b expected 0001", {pll_rst_o, drp_den_o, cfg_ready_o, busy_o});
        end
        test_reset();
        test_powerup();
    endtask

    task automatic test_lock_loss;
        @(negedge clk);
        pll_locked_i = 1'b0;
        @(negedge clk);
        pll_locked_i = 1'b1;
        n_chk++;
        if ({locked_o, err_o, busy_o} !== 3'b010) begin
            n_fail++; $display("FAIL lock_loss: got %b expected 010", {locked_o, err_o, busy_o});
        end
        repeat (3) @(negedge clk);
        n_chk++;
        if ({locked_o, err_o} !== 2'b01) begin
            n_fail++; $display("FAIL lock_loss_sticky: got %b expected 01", {locked_o, err_o});
        end
    endtask

    task automatic test_lock_timeout;
        int k = -1;
        @(negedge clk);
        reset_i = 1'b1; pll_locked_i = 1'b0;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        for (int i = 1; i <= 70000; i++) begin
            @(negedge clk);
            if (done_o) begin k = i; break; end
            if (i % 50 == 0) pll_locked_i = ~pll_locked_i;
        end
        n_chk++;
        if (k != 65535 || locked_o !== 1'b0 || err_o !== 1'b1) begin
            n_fail++; $display("FAIL lock_timeout: got %0d %b %b expected 65535 0 1", k, locked_o, err_o);
        end
        @(negedge clk);
        n_chk++;
        if ({done_o, busy_o, cfg_ready_o} !== 3'b001) begin
            n_fail++; $display("FAIL lock_timeout_idle: got %b expected 001", {done_o, busy_o, cfg_ready_o});
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) drp_mem[i] = 16'h0;
        test_reset();
        test_powerup();
        test_single();
        test_burst();
        test_drdy_timeout();
        test_reset_in_next();
        test_lock_loss();
        test_lock_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
